// File: rtl/writeback_queue.sv
// ---------------------------------------------------------------------------
// writeback_queue
//   Write-back stage for the RV64 sequential core. Accepts results from the
//   ALU and from the load/store unit, formats load data by funct3 and byte
//   offset, buffers results in an in-order FIFO and drains one register-file
//   write per cycle. A pending-write vector lets decode stall on RAW hazards.
//
//   Optional feature macro: WB_FORWARD_EN
//     Adds a two-port forwarding lookup (youngest queued value for rs1/rs2).
//
// Parameters
//   DEPTH : FIFO entries (power of two, >= 2)
//   CW    : width of the occupancy count
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   alu_valid/ready/rd/data  ALU result handshake
//   mem_valid/ready/rd/raw   load result handshake (raw aligned doubleword)
//   mem_funct3, mem_offset   load type and byte address[2:0]
//   rf_reg_write/rd_addr/rd_data  register-file write port
//   pending                  bit i set while a write to xi is queued
//   count                    current FIFO occupancy
//   fwd_rs{1,2}_addr/hit/data  forwarding lookup (WB_FORWARD_EN only)
// ---------------------------------------------------------------------------
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [4:0]    alu_rd,
  input  logic [63:0]   alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [4:0]    mem_rd,
  input  logic [63:0]   mem_raw,
  input  logic [2:0]    mem_funct3,
  input  logic [2:0]    mem_offset,
`ifdef WB_FORWARD_EN
  input  logic [4:0]    fwd_rs1_addr,
  input  logic [4:0]    fwd_rs2_addr,
  output logic          fwd_rs1_hit,
  output logic          fwd_rs2_hit,
  output logic [63:0]   fwd_rs1_data,
  output logic [63:0]   fwd_rs2_data,
`endif
  output logic          rf_reg_write,
  output logic [4:0]    rf_rd_addr,
  output logic [63:0]   rf_rd_data,
  output logic [31:0]   pending,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // FIFO storage and pointers
  logic [DEPTH-1:0]       ent_vld_q,  ent_vld_d;
  logic [DEPTH-1:0][4:0]  ent_rd_q,   ent_rd_d;
  logic [DEPTH-1:0][63:0] ent_data_q, ent_data_d;
  logic [PW-1:0]          rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0]          wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0]          count_q,    count_d;

  logic        not_full;
  logic        mem_fire, alu_fire;
  logic        enq, deq;
  logic [4:0]  enq_rd;
  logic [63:0] enq_data;
  logic [63:0] load_data;

  // Load formatting: shift the selected byte lane down to bit 0 (bytes
  // shifted in from above bit 63 are zero), then sign/zero extend.
  function automatic logic [63:0] load_fmt(input logic [63:0] raw,
                                           input logic [2:0]  f3,
                                           input logic [2:0]  off);
    logic [63:0] sh;
    sh = raw >> {off, 3'b000};
    case (f3)
      3'b000:  return {{56{sh[7]}},  sh[7:0]};
      3'b001:  return {{48{sh[15]}}, sh[15:0]};
      3'b010:  return {{32{sh[31]}}, sh[31:0]};
      3'b100:  return {56'd0, sh[7:0]};
      3'b101:  return {48'd0, sh[15:0]};
      3'b110:  return {32'd0, sh[31:0]};
      default: return sh;  // LD and the unused 111 encoding
    endcase
  endfunction

  assign load_data = load_fmt(mem_raw, mem_funct3, mem_offset);

  // Readiness is derived from registered occupancy only; a pop in the same
  // cycle does not free a slot for the incoming result.
  assign not_full  = (count_q < CW'(DEPTH));
  assign mem_ready = !rst && not_full;
  assign alu_ready = !rst && not_full && !mem_valid;

  assign mem_fire  = mem_valid && mem_ready;
  assign alu_fire  = alu_valid && alu_ready;

  always_comb begin
    enq_rd   = alu_rd;
    enq_data = alu_data;
    if (mem_fire) begin
      enq_rd   = mem_rd;
      enq_data = load_data;
    end
  end

  // x0 results complete the handshake but never occupy a slot.
  assign enq = (mem_fire || alu_fire) && (enq_rd != 5'd0);
  assign deq = (count_q != '0);

  // Next-state: pop head, push tail. enq only happens when not full and deq
  // only when not empty, so the two never target the same slot.
  always_comb begin
    ent_vld_d  = ent_vld_q;
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + CW'(enq) - CW'(deq);
    if (deq) begin
      ent_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d            = rd_ptr_q + PW'(1);
    end
    if (enq) begin
      ent_vld_d[wr_ptr_q]  = 1'b1;
      ent_rd_d[wr_ptr_q]   = enq_rd;
      ent_data_d[wr_ptr_q] = enq_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld_q  <= '0;
      ent_rd_q   <= '0;
      ent_data_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      ent_vld_q  <= ent_vld_d;
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  assign count = count_q;

  // Head of the queue drives the register file whenever it is non-empty.
  always_comb begin
    rf_reg_write = 1'b0;
    rf_rd_addr   = 5'd0;
    rf_rd_data   = 64'd0;
    if (!rst && deq) begin
      rf_reg_write = 1'b1;
      rf_rd_addr   = ent_rd_q[rd_ptr_q];
      rf_rd_data   = ent_data_q[rd_ptr_q];
    end
  end

  // Pending vector: OR of one-hot rd decodes of all live entries.
  always_comb begin
    pending = 32'd0;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld_q[i]) pending[ent_rd_q[i]] = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

`ifdef WB_FORWARD_EN
  // Walk entries from oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_rs1_hit  = 1'b0;
    fwd_rs2_hit  = 1'b0;
    fwd_rs1_data = 64'd0;
    fwd_rs2_data = 64'd0;
    idx          = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (fwd_rs1_addr != 5'd0 && ent_rd_q[idx] == fwd_rs1_addr) begin
          fwd_rs1_hit  = 1'b1;
          fwd_rs1_data = ent_data_q[idx];
        end
        if (fwd_rs2_addr != 5'd0 && ent_rd_q[idx] == fwd_rs2_addr) begin
          fwd_rs2_hit  = 1'b1;
          fwd_rs2_data = ent_data_q[idx];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// ---------------------------------------------------------------------------
// tb_writeback_queue
//   Self-checking bench: directed cases plus randomized traffic, compared
//   every cycle against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_writeback_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, alu_ready;
  logic [4:0]    alu_rd;
  logic [63:0]   alu_data;
  logic          mem_valid, mem_ready;
  logic [4:0]    mem_rd;
  logic [63:0]   mem_raw;
  logic [2:0]    mem_funct3, mem_offset;
  logic          rf_reg_write;
  logic [4:0]    rf_rd_addr;
  logic [63:0]   rf_rd_data;
  logic [31:0]   pending;
  logic [CW-1:0] count;
`ifdef WB_FORWARD_EN
  logic [4:0]    fwd_rs1_addr, fwd_rs2_addr;
  logic          fwd_rs1_hit, fwd_rs2_hit;
  logic [63:0]   fwd_rs1_data, fwd_rs2_data;
`endif

  always #5 clk = ~clk;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_raw(mem_raw),
    .mem_funct3(mem_funct3), .mem_offset(mem_offset),
`ifdef WB_FORWARD_EN
    .fwd_rs1_addr(fwd_rs1_addr), .fwd_rs2_addr(fwd_rs2_addr),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
`endif
    .rf_reg_write(rf_reg_write), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .pending(pending), .count(count)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] d;
  } ent_t;

  ent_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference load formatting built byte by byte from the load rules.
  function automatic logic [63:0] ref_load(input logic [63:0] raw, input logic [2:0] f3,
                                           input logic [2:0] off);
    logic [7:0] b [8];
    logic [63:0] v;
    int nbytes;
    bit sgn;
    for (int i = 0; i < 8; i++)
      b[i] = (int'(off) + i < 8) ? raw[8*(int'(off)+i) +: 8] : 8'h00;
    case (f3)
      3'd0: begin nbytes = 1; sgn = 1; end
      3'd1: begin nbytes = 2; sgn = 1; end
      3'd2: begin nbytes = 4; sgn = 1; end
      3'd4: begin nbytes = 1; sgn = 0; end
      3'd5: begin nbytes = 2; sgn = 0; end
      3'd6: begin nbytes = 4; sgn = 0; end
      default: begin nbytes = 8; sgn = 0; end
    endcase
    for (int i = 0; i < 8; i++) begin
      if (i < nbytes) v[8*i +: 8] = b[i];
      else            v[8*i +: 8] = (sgn && b[nbytes-1][7]) ? 8'hFF : 8'h00;
    end
    return v;
  endfunction

  // One clock: model update at the edge, then compare outputs at negedge.
  task automatic cyc();
    bit         mr, ar;
    logic [31:0] pend;
    ent_t       e;
    @(posedge clk);
    mr = !rst && (q.size() < DEPTH);
    ar = mr && !mem_valid;
    if (rst) q.delete();
    else begin
      if (q.size() > 0) void'(q.pop_front());
      if (mem_valid && mr) begin
        if (mem_rd != 0) begin
          e.rd = mem_rd; e.d = ref_load(mem_raw, mem_funct3, mem_offset);
          q.push_back(e);
        end
      end else if (alu_valid && ar && alu_rd != 0) begin
        e.rd = alu_rd; e.d = alu_data;
        q.push_back(e);
      end
    end
    @(negedge clk);
    pend = 32'd0;
    foreach (q[i]) pend[q[i].rd] = 1'b1;
    pend[0] = 1'b0;
    chk("count", 64'(count), 64'(q.size()));
    chk("pending", 64'(pending), rst ? 64'd0 : 64'(pend));
    chk("rf_we", 64'(rf_reg_write), 64'(!rst && q.size() > 0));
    chk("rf_addr", 64'(rf_rd_addr), (!rst && q.size() > 0) ? 64'(q[0].rd) : 64'd0);
    chk("rf_data", rf_rd_data, (!rst && q.size() > 0) ? q[0].d : 64'd0);
    chk("mem_ready", 64'(mem_ready), 64'(!rst && q.size() < DEPTH));
    chk("alu_ready", 64'(alu_ready), 64'(!rst && q.size() < DEPTH && !mem_valid));
`ifdef WB_FORWARD_EN
    begin
      bit h1 = 0, h2 = 0;
      logic [63:0] d1 = 0, d2 = 0;
      if (!rst) foreach (q[i]) begin
        if (fwd_rs1_addr != 0 && q[i].rd == fwd_rs1_addr) begin h1 = 1; d1 = q[i].d; end
        if (fwd_rs2_addr != 0 && q[i].rd == fwd_rs2_addr) begin h2 = 1; d2 = q[i].d; end
      end
      chk("fwd1_hit", 64'(fwd_rs1_hit), 64'(h1));
      chk("fwd1_data", fwd_rs1_data, d1);
      chk("fwd2_hit", 64'(fwd_rs2_hit), 64'(h2));
      chk("fwd2_data", fwd_rs2_data, d2);
    end
`endif
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0;
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic [63:0] d);
    alu_valid = 1; alu_rd = rd; alu_data = d; mem_valid = 0;
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [63:0] raw,
                         input logic [2:0] f3, input logic [2:0] off);
    mem_valid = 1; mem_rd = rd; mem_raw = raw; mem_funct3 = f3; mem_offset = off;
  endtask

  localparam logic [63:0] RAW = 64'h8877_6655_4433_2211;

  initial begin
    rst = 1; alu_valid = 0; mem_valid = 0; alu_rd = 0; alu_data = 0;
    mem_rd = 0; mem_raw = 0; mem_funct3 = 0; mem_offset = 0;
`ifdef WB_FORWARD_EN
    fwd_rs1_addr = 7; fwd_rs2_addr = 5;
`endif
    cyc(); cyc();
    rst = 0;
    cyc();
    chk("idle_mem_rdy", 64'(mem_ready), 64'd1);
    chk("idle_alu_rdy", 64'(alu_ready), 64'd1);

    // ALU x5 = 0x1234
    do_alu(5'd5, 64'h1234); cyc(); idle();
    chk("alu_addr", 64'(rf_rd_addr), 64'd5);
    chk("alu_data", rf_rd_data, 64'h1234);
    chk("alu_pend5", 64'(pending[5]), 64'd1);
    cyc();
    chk("alu_pend5_clr", 64'(pending[5]), 64'd0);

    // Load formatting corner cases
    do_load(5'd9, RAW, 3'b000, 3'd7); cyc(); idle();
    chk("lb_off7", rf_rd_data, 64'hFFFF_FFFF_FFFF_FF88);
    do_load(5'd9, RAW, 3'b101, 3'd4); cyc(); idle();
    chk("lhu_off4", rf_rd_data, 64'h0000_0000_0000_6655);
    do_load(5'd9, RAW, 3'b010, 3'd0); cyc(); idle();
    chk("lw_off0", rf_rd_data, 64'h0000_0000_4433_2211);
    cyc();

    // Simultaneous load and ALU: load wins, ALU follows
    do_load(5'd3, RAW, 3'b011, 3'd0); do_alu(5'd4, 64'hABCD); mem_valid = 1;
    #1 chk("alu_blocked", 64'(alu_ready), 64'd0);
    cyc(); mem_valid = 0;
    chk("arb_first", 64'(rf_rd_addr), 64'd3);
    cyc(); idle();
    chk("arb_second", 64'(rf_rd_addr), 64'd4);
    cyc();

    // x0 result: accepted, not queued
    do_alu(5'd0, 64'hDEAD);
    #1 chk("x0_ready", 64'(alu_ready), 64'd1);
    cyc(); idle();
    chk("x0_nowrite", 64'(rf_reg_write), 64'd0);

    // Back-to-back x7 writes
    do_alu(5'd7, 64'hA); cyc(); do_alu(5'd7, 64'hB); cyc(); idle(); cyc();

    // Reset mid-operation
    do_alu(5'd12, 64'h55); cyc(); rst = 1; idle(); cyc(); rst = 0; cyc();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      mem_valid  = ($urandom_range(0, 2) == 0);
      alu_valid  = ($urandom_range(0, 1) == 0);
      mem_rd     = 5'($urandom_range(0, 7));
      alu_rd     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      alu_data   = {$urandom, $urandom};
      mem_raw    = {$urandom, $urandom};
      mem_funct3 = 3'($urandom);
      mem_offset = 3'($urandom);
`ifdef WB_FORWARD_EN
      fwd_rs1_addr = 5'($urandom_range(0, 7));
      fwd_rs2_addr = 5'($urandom_range(0, 7));
`endif
      rst = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 0; idle(); cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
